// File: rtl/mdu_pkg.sv
// Shared op-code and FSM definitions for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step
// on the {hi,lo} working pair.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;

  always_comb begin
    addend = lo_i[0] ? opnd_i : '0;
    sum    = {1'b0, hi_i} + {1'b0, addend};
    shl    = {hi_i, lo_i[WIDTH-1]};
    // the remainder after a successful subtract is below the divisor, so W bits suffice
    diff   = shl[WIDTH-1:0] - opnd_i;
    hi_o   = sum[WIDTH:1];
    lo_o   = {sum[0], lo_i[WIDTH-1:1]};
    if (div_mode) begin
      if (shl >= {1'b0, opnd_i}) begin
        hi_o = diff;
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shl[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// Magnitudes are iterated unsigned; signs are applied in the FIX state.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             is_mul, is_div, sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (div_q),
    .hi_i     (wh_q),
    .lo_i     (wl_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    is_mul   = (op == MDU_MULT) || (op == MDU_MULTU);
    is_div   = (op == MDU_DIV)  || (op == MDU_DIVU);
    sgn_op   = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg    = sgn_op && a[WIDTH-1];
    b_neg    = sgn_op && b[WIDTH-1];
    a_mag    = a_neg ? {WIDTH{1'b0}} - a : a;
    b_mag    = b_neg ? {WIDTH{1'b0}} - b : b;
    prod     = {wh_q, wl_q};
    prod_fix = neg_lo_q ? {2*WIDTH{1'b0}} - prod : prod;
    q_fix    = neg_lo_q ? {WIDTH{1'b0}} - wl_q : wl_q;
    r_fix    = neg_hi_q ? {WIDTH{1'b0}} - wh_q : wh_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    opnd_d     = opnd_q;
    wh_d       = wh_q;
    wl_d       = wl_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            state_d  = RUN;
            cnt_d    = '0;
            div_d    = is_div;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = is_div && a_neg;
            dz_d     = is_div && (b == '0);
            opnd_d   = is_div ? b_mag : a_mag;
            wh_d     = '0;
            wl_d     = is_div ? a_mag : b_mag;
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        wh_d  = step_hi;
        wl_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d    = IDLE;
        cnt_d      = '0;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (div_q) begin
          // with a zero divisor every trial subtract succeeds, leaving |a| as the
          // remainder; the dividend sign fix then restores a exactly
          hi_d = r_fix;
          lo_d = dz_q ? {WIDTH{1'b1}} : q_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      opnd_q     <= '0;
      wh_q       <= '0;
      wl_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      opnd_q     <= opnd_d;
      wh_q       <= wh_d;
      wl_q       <= wl_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at WIDTH=32 with hand-computed results.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, busy, done, div_zero;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  int lat, bcnt, dcnt;
  bit stab;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request for exactly one edge; returns 1ns after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit now);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
  endtask

  // Waits (bounded) for done; reports edges waited, busy cycles and HI/LO stability.
  task automatic wait_done(output int l, output int bc, output bit st);
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo;
    l = 0; bc = busy ? 1 : 0; st = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin l = k; break; end
      if (busy) bc++;
      if (hi !== h0 || lo !== l0) st = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;

    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy_cycles", 64'(bcnt), 64'd33);
    chk("multu_stable", 64'(stab), 64'd1);
    chk("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);
    chk("multu_dz", 64'(div_zero), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {62'd0, done, busy}, 64'd0);

    issue(MDU_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("mult_neg3x7", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    issue(MDU_MULT, 32'h80000000, 32'h80000000, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("mult_minsq", {hi, lo}, 64'h40000000_00000000);

    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(MDU_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("div_7_neg2", {hi, lo}, 64'h00000001_FFFFFFFD);

    issue(MDU_DIVU, 32'd7, 32'd2, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("divu_7_2", {hi, lo}, 64'h00000001_00000003);

    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    chk("div_ovf_dz", 64'(div_zero), 64'd0);

    issue(MDU_DIVU, 32'd5, 32'd0, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("divu_by0_lat", 64'(lat), 64'd33);
    chk("divu_by0", {hi, lo}, 64'h00000005_FFFFFFFF);
    chk("divu_by0_dz", 64'(div_zero), 64'd1);

    issue(MDU_DIV, 32'hFFFFFFF8, 32'd0, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("div_neg_by0", {hi, lo}, 64'hFFFFFFF8_FFFFFFFF);
    chk("div_neg_by0_dz", 64'(div_zero), 64'd1);

    issue(MDU_DIVU, 32'd6, 32'd3, 1'b0);
    wait_done(lat, bcnt, stab);
    chk("divu_6_3", {hi, lo}, 64'h00000000_00000002);
    chk("divu_6_3_dz", 64'(div_zero), 64'd0);

    issue(MDU_MTHI, 32'h00001234, 32'd0, 1'b0);
    chk("mthi", {hi, lo}, 64'h00001234_00000002);
    chk("mthi_flags", {62'd0, busy, done}, 64'd0);

    issue(3'd6, 32'hDEADBEEF, 32'd1, 1'b0);
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy || done) dcnt++;
      @(posedge clk); #1;
    end
    chk("noop_flags", 64'(dcnt), 64'd0);
    chk("noop_hilo", {hi, lo}, 64'h00001234_00000002);

    issue(MDU_DIVU, 32'd7, 32'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = MDU_MTLO; a = 32'h0000AAAA;
    @(posedge clk); #1;
    start = 1'b0; a = '0;
    chk("mtlo_busy_ignored", {hi, lo}, 64'h00001234_00000002);
    wait_done(lat, bcnt, stab);
    chk("mtlo_busy_lat", 64'(lat), 64'd29);
    chk("mtlo_busy_stable", 64'(stab), 64'd1);
    chk("mtlo_busy_res", {hi, lo}, 64'h00000001_00000003);

    issue(MDU_MULTU, 32'd2, 32'd3, 1'b1);
    wait_done(lat, bcnt, stab);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_res", {hi, lo}, 64'h00000000_00000006);

    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    dcnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);

    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = MDU_MTHI; a = 32'h55;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; a = '0;
    @(posedge clk); #1;
    chk("rst_over_start", {hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
